// File: rtl/dcache_mem_stage.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add hit/miss counter outputs.
module dcache_mem_stage #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned TAG_W     = 27 - $clog2(NUM_LINES)
) (
    input  logic          clock_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [255:0]  mem_wdata_o,
    input  logic [255:0]  mem_rdata_i,
    input  logic          mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o
`endif
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [255:0]           data_q [NUM_LINES];

    logic [INDEX_W-1:0]     idx;
    logic [TAG_W-1:0]       addr_tag;
    logic [7:0]             word_lsb;
    logic                   hit;
    logic                   write_hit;
    logic                   wb_ack;
    logic                   alloc_ack;
    logic                   unused_addr;

    assign idx         = addr_i[5+INDEX_W-1:5];
    assign addr_tag    = addr_i[31:5+INDEX_W];
    assign word_lsb    = {addr_i[4:2], 5'b0};
    assign unused_addr = ^addr_i[1:0];
    assign hit         = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign write_hit   = (state_q == StIdle) && req_i && we_i && hit;
    assign wb_ack      = (state_q == StWriteback) && mem_ack_i;
    assign alloc_ack   = (state_q == StAllocate) && mem_ack_i;

    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        rdata_o     = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (hit) begin
                        if (!we_i) rdata_o = data_q[idx][word_lsb +: 32];
                    end else begin
                        stall_o = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                    end
                end
            end
            StWriteback: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, 5'b0};
                mem_wdata_o = data_q[idx];
                if (mem_ack_i) state_d = StAllocate;
            end
            StAllocate: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_i[31:5], 5'b0};
                if (mem_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (write_hit) dirty_q[idx] <= 1'b1;
            if (wb_ack)    dirty_q[idx] <= 1'b0;
            if (alloc_ack) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clock_i) begin
        if (write_hit) data_q[idx][word_lsb +: 32] <= wdata_i;
        if (alloc_ack) begin
            data_q[idx] <= mem_rdata_i;
            tag_q[idx]  <= addr_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        refill_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // The IDLE cycle right after a refill replays the missed access; it is not a hit.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refill_q <= alloc_ack;
            if ((state_q == StIdle) && req_i && hit && !refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state_q == StIdle) && req_i && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Self-checking bench for dcache_mem_stage: scenario tasks plus randomized traffic
// checked against a line-level cache/memory model.
module tb_dcache_mem_stage;

    logic          clock_i = 1'b0;
    logic          rst_i;
    logic          req_i, we_i;
    logic [31:0]   addr_i, wdata_i, rdata_o;
    logic          stall_o, mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [255:0]  mem_wdata_o, mem_rdata_i;
    logic          mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

    always #5 clock_i = ~clock_i;

    dcache_mem_stage #(.NUM_LINES(32)) dut (
        .clock_i     (clock_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    // Reference model: cache contents per line plus a sparse backing memory.
    bit           m_valid [32];
    bit           m_dirty [32];
    bit [21:0]    m_tag   [32];
    bit [255:0]   m_data  [32];
    bit [255:0]   mem     [bit [31:0]];
    int           m_hits, m_misses;
    int           checks, errors;

    function automatic bit [255:0] mem_line(input bit [31:0] la);
        bit [255:0] l;
        if (!mem.exists(la)) begin
            for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
            mem[la] = l;
        end
        return mem[la];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // One complete CPU access, acting as the backing memory with 'delay' cycles before ack.
    task automatic access(input bit we, input bit [31:0] addr, input bit [31:0] wd,
                          input int delay, output bit missed, output bit wb_seen);
        int         idx, w;
        bit [21:0]  tg;
        bit         hit;
        bit [31:0]  va, la, exp_rd;
        idx = int'(addr[9:5]);
        w   = int'(addr[4:2]);
        tg  = addr[31:10];
        la  = {addr[31:5], 5'b0};
        hit = m_valid[idx] && (m_tag[idx] == tg);
        missed  = !hit;
        wb_seen = 1'b0;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
        @(negedge clock_i);
        exp_rd = (hit && !we) ? m_data[idx][w*32 +: 32] : 32'h0;
        checks++;
        if ({stall_o, mem_req_o, rdata_o} !== {!hit, 1'b0, exp_rd}) begin
            errors++;
            $display("FAIL first_eval addr=%h we=%b: stall=%b mem_req=%b rdata=%h, want stall=%b mem_req=0 rdata=%h",
                     addr, we, stall_o, mem_req_o, rdata_o, !hit, exp_rd);
        end
        if (!hit) begin
            m_misses++;
            step();
            if (m_valid[idx] && m_dirty[idx]) begin
                wb_seen = 1'b1;
                va = {m_tag[idx], idx[4:0], 5'b0};
                for (int k = 0; k <= delay; k++) begin
                    mem_ack_i   = (k == delay);
                    mem_rdata_i = {8{$urandom}};
                    @(negedge clock_i);
                    checks++;
                    if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, rdata_o} !==
                        {1'b1, 1'b1, 1'b1, va, 32'h0}) begin
                        errors++;
                        $display("FAIL writeback cyc%0d: stall=%b req=%b we=%b addr=%h rdata=%h, want 1 1 1 %h 0",
                                 k, stall_o, mem_req_o, mem_we_o, mem_addr_o, rdata_o, va);
                    end
                    checks++;
                    if (mem_wdata_o !== m_data[idx]) begin
                        errors++;
                        $display("FAIL writeback_data: got %h want %h", mem_wdata_o, m_data[idx]);
                    end
                    step();
                end
                mem[va] = m_data[idx];
                m_dirty[idx] = 1'b0;
            end
            for (int k = 0; k <= delay; k++) begin
                mem_ack_i   = (k == delay);
                mem_rdata_i = (k == delay) ? mem_line(la) : {8{$urandom}};
                @(negedge clock_i);
                checks++;
                if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, rdata_o, mem_wdata_o} !==
                    {1'b1, 1'b1, 1'b0, la, 32'h0, 256'h0}) begin
                    errors++;
                    $display("FAIL allocate cyc%0d: stall=%b req=%b we=%b addr=%h rdata=%h, want 1 1 0 %h 0",
                             k, stall_o, mem_req_o, mem_we_o, mem_addr_o, rdata_o, la);
                end
                step();
            end
            mem_ack_i    = 1'b0;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_line(la);
            exp_rd = we ? 32'h0 : m_data[idx][w*32 +: 32];
            @(negedge clock_i);
            checks++;
            if ({stall_o, mem_req_o, rdata_o} !== {1'b0, 1'b0, exp_rd}) begin
                errors++;
                $display("FAIL refill_replay addr=%h: stall=%b mem_req=%b rdata=%h, want 0 0 %h",
                         addr, stall_o, mem_req_o, rdata_o, exp_rd);
            end
        end else begin
            m_hits++;
        end
        if (we) begin
            m_data[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        step();
        req_i     = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    // Idle cycles with stray acks, which the cache must ignore.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_i       = 1'b0;
            addr_i      = $urandom;
            mem_ack_i   = 1'($urandom);
            mem_rdata_i = {8{$urandom}};
            @(negedge clock_i);
            checks++;
            if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o} !== '0) begin
                errors++;
                $display("FAIL idle: stall=%b req=%b we=%b addr=%h rdata=%h, want all 0",
                         stall_o, mem_req_o, mem_we_o, mem_addr_o, rdata_o);
            end
            step();
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic check_stats(input string name);
`ifdef DCACHE_STATS_EN
        checks++;
        if ({hit_cnt_o, miss_cnt_o} !== {32'(m_hits), 32'(m_misses)}) begin
            errors++;
            $display("FAIL %s: hit_cnt=%0d miss_cnt=%0d, want %0d %0d",
                     name, hit_cnt_o, miss_cnt_o, m_hits, m_misses);
        end
`endif
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) step();
        rst_i = 1'b0;
        model_reset();
        idle(2);
        check_stats("reset_stats");
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0044;
        @(negedge clock_i);
        checks++;
        if ({stall_o, mem_req_o, rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_cold_stall: stall=%b mem_req=%b rdata=%h, want 1 0 0",
                     stall_o, mem_req_o, rdata_o);
        end
        req_i = 1'b0;
        step();
    endtask

    task automatic test_cold_load();
        bit [255:0] l;
        bit missed, wb;
        l = mem_line(32'h40);
        l[63:32] = 32'hDEAD_BEEF;
        mem[32'h40] = l;
        access(1'b0, 32'h0000_0044, 32'h0, 0, missed, wb);
        checks++;
        if ({missed, wb} !== 2'b10) begin
            errors++;
            $display("FAIL cold_load: missed=%b wb=%b, want 1 0", missed, wb);
        end
    endtask

    task automatic test_store_hit();
        bit missed, wb;
        access(1'b1, 32'h0000_0044, 32'h1234_5678, 0, missed, wb);
        checks++;
        if (missed !== 1'b0) begin
            errors++;
            $display("FAIL store_hit: missed=%b, want 0", missed);
        end
        access(1'b0, 32'h0000_0044, 32'h0, 0, missed, wb);
    endtask

    task automatic test_dirty_evict();
        bit missed, wb;
        access(1'b0, 32'h0000_0444, 32'h0, 1, missed, wb);
        checks++;
        if ({missed, wb} !== 2'b11 || mem[32'h40][63:32] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dirty_evict: missed=%b wb=%b word1=%h, want 1 1 12345678",
                     missed, wb, mem[32'h40][63:32]);
        end
    endtask

    task automatic test_clean_evict();
        bit missed, wb;
        access(1'b0, 32'h0000_0844, 32'h0, 0, missed, wb);
        checks++;
        if ({missed, wb} !== 2'b10) begin
            errors++;
            $display("FAIL clean_evict: missed=%b wb=%b, want 1 0", missed, wb);
        end
    endtask

    task automatic test_ack_latency();
        bit missed, wb;
        access(1'b1, 32'h0000_1048, 32'hA5A5_0001, 5, missed, wb);
        access(1'b0, 32'h0000_0848, 32'h0, 5, missed, wb);
        checks++;
        if ({missed, wb} !== 2'b11) begin
            errors++;
            $display("FAIL ack_latency: missed=%b wb=%b, want 1 1", missed, wb);
        end
    endtask

    task automatic test_reset_mid_alloc();
        bit missed, wb;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0C44;
        step();
        @(negedge clock_i);
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h0000_0C40}) begin
            errors++;
            $display("FAIL mid_alloc: req=%b we=%b addr=%h, want 1 0 00000c40",
                     mem_req_o, mem_we_o, mem_addr_o);
        end
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        model_reset();
        @(negedge clock_i);
        checks++;
        if ({mem_req_o, stall_o} !== 2'b01) begin
            errors++;
            $display("FAIL reset_abandon: mem_req=%b stall=%b, want 0 1", mem_req_o, stall_o);
        end
        check_stats("stats_after_reset");
        req_i = 1'b0;
        step();
        access(1'b0, 32'h0000_0044, 32'h0, 0, missed, wb);
        checks++;
        if ({missed, wb} !== 2'b10) begin
            errors++;
            $display("FAIL reload_after_reset: missed=%b wb=%b, want 1 0", missed, wb);
        end
    endtask

    task automatic test_back_to_back();
        bit missed, wb;
        bit [31:0] a;
        for (int i = 0; i < 20; i++) begin
            a = {20'h0, 2'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 3'($urandom), 2'b00};
            access(1'b1, a, $urandom, 0, missed, wb);
            access(1'b0, a, 32'h0, 0, missed, wb);
        end
    endtask

    task automatic test_random();
        bit missed, wb;
        bit [31:0] a;
        for (int i = 0; i < 300; i++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
            access(1'($urandom), a, $urandom, $urandom_range(0, 3), missed, wb);
            idle($urandom_range(0, 2));
        end
        check_stats("random_stats");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_clean_evict();
        test_ack_latency();
        test_reset_mid_alloc();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
- Direct-mapped, write-back, write-allocate data cache occupying the MEM stage.
- Fed by the EX/MEM register; its read data and stall feed the MEM/WB register (MEM/WB enable_i = ~stall_o).
- Misses go to a slow 256-bit-line backing memory over a req/ack handshake.
- The whole pipeline freezes while stall_o is high.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2, >= 2); INDEX_W = log2(NUM_LINES).
- TAG_W, 27 - INDEX_W, tag width: address bits [31:5+INDEX_W].

Ports:
- clock_i  in  1  rising-edge clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  1  CPU access valid this cycle (MemRead | MemWrite)
- we_i  in  1  1 = store, 0 = load (qualified by req_i)
- addr_i  in  32  byte address; [1:0] ignored, [4:2] word select, [5+INDEX_W-1:5] index, rest tag
- wdata_i  in  32  store data
- rdata_o  out  32  load data (valid when req_i & ~we_i & ~stall_o)
- stall_o  out  1  freeze pipeline; pipeline holds req_i/we_i/addr_i/wdata_i stable while high
- mem_req_o  out  1  backing-memory request
- mem_we_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line-aligned address, [4:0] = 0
- mem_wdata_o  out  256  victim line data
- mem_rdata_i  in  256  fetched line, valid when mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W-1:0], data[255:0]. Word w occupies bits [32w+31:32w].
- hit = valid[idx] & (tag[idx] == addr tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - stall_o = req_i & ~hit, combinational in the same cycle.
  - Read hit: rdata_o = selected word, combinationally, zero added latency.
  - Write hit: the word is written at the posedge and dirty is set. Read-after-write to the same word in the next cycle returns the new value.
  - Miss with victim valid & dirty: next state WRITEBACK.
  - Miss otherwise: next state ALLOCATE.
  - No request: no state change.
- WRITEBACK:
  - stall_o = 1, mem_req_o = 1, mem_we_o = 1.
  - mem_addr_o = {victim tag, idx, 5'b0}; mem_wdata_o = victim line.
  - Outputs held stable until mem_ack_i. On ack: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - stall_o = 1, mem_req_o = 1, mem_we_o = 0, mem_addr_o = {addr_i[31:5], 5'b0}.
  - On ack: line data = mem_rdata_i, tag = addr tag, valid = 1, dirty = 0. Go to IDLE.
- Post-refill: the next IDLE cycle re-evaluates the access as a hit.
  - Load: stall_o drops and rdata_o is valid.
  - Store: the word is merged at that posedge and dirty is set.
  - Miss penalty = 1 + handshake cycles per memory transaction.
- Output defaults:
  - mem_req_o = 0 in IDLE.
  - mem_we_o, mem_addr_o and mem_wdata_o = 0 when mem_req_o = 0.
  - rdata_o = 0 when there is no read hit.
- mem_ack_i in IDLE is ignored.
- Ack arriving in the same cycle the request is first asserted is legal and completes that transaction.
- Reset (any state, including mid-handshake):
  - At the posedge: state = IDLE, all valid and dirty bits cleared, mem_req_o = 0 the next cycle, and the pending transaction is abandoned.
  - Tag and data contents are don't-care.
  - stall_o follows the IDLE rule after reset.
- req_i deasserted while stall_o is high is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- With the macro:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], reset to 0.
  - hit_cnt_o increments once per completed access that hit on first evaluation.
  - miss_cnt_o increments once per IDLE -> WRITEBACK or IDLE -> ALLOCATE transition.
  - The post-refill re-evaluation is not counted as a hit.
  - Counters wrap at 2^32.
- Without the macro: the ports and counters are absent and the logic is identical otherwise.

Test Plan:
- Cold load miss:
  - After reset, load addr 0x0000_0044.
  - Expect stall_o = 1, ALLOCATE with mem_addr_o = 0x0000_0040, mem_we_o = 0.
  - Ack with line word1 = 0xDEAD_BEEF; the next cycle gives stall_o = 0 and rdata_o = 0xDEAD_BEEF.
- Store hit then load:
  - Store 0x1234_5678 to 0x44 with no stall.
  - The next-cycle load of 0x44 returns 0x1234_5678 and the line is dirty.
- Dirty eviction:
  - With NUM_LINES = 32, load 0x0000_0444 (same index, new tag).
  - First WRITEBACK: mem_addr_o = 0x40, mem_we_o = 1, mem_wdata_o word1 = 0x1234_5678.
  - Then ALLOCATE: mem_addr_o = 0x440.
- Clean eviction: evict a clean line; no WRITEBACK occurs and the block goes straight to ALLOCATE.
- Ack latency hold: delay mem_ack_i by 5 cycles; mem_req_o, mem_addr_o and stall_o stay constant for all 5 cycles.
- Reset mid-ALLOCATE:
  - Assert rst_i before ack; the next cycle shows mem_req_o = 0.
  - A reload of 0x44 misses again.
  - With DCACHE_STATS_EN, both counters read 0 after reset.
